// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - shared mode encodings for the universal shift register
package usr_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } usr_mode_e;

  function automatic logic is_shift(input logic [1:0] mode);
    return (mode == MODE_SHR) || (mode == MODE_SHL);
  endfunction

endpackage

// File: rtl/shift_counter.sv
// rtl/shift_counter.sv - modulo-WIDTH shift counter with registered wrap pulse
module shift_counter #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     inc,
  output logic [$clog2(WIDTH)-1:0] count,
  output logic                     wrap
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // wrap is high only for the cycle following the WIDTH-th increment
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (inc) begin
      if (count == LAST) begin
        count <= '0;
        wrap  <= 1'b1;
      end else begin
        count <= count + 1'b1;
        wrap  <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/universal_shift_register.sv
// rtl/universal_shift_register.sv - hold/shift/rotate/load register with word counter
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic                     rotate,
  input  logic                     serial_in_r,
  input  logic                     serial_in_l,
  input  logic [WIDTH-1:0]         parallel_in,
  output logic [WIDTH-1:0]         parallel_out,
  output logic                     serial_out_r,
  output logic                     serial_out_l,
  output logic [$clog2(WIDTH)-1:0] shift_count,
  output logic                     word_done
);

  logic [WIDTH-1:0] q;
  usr_mode_e        mode_e;

  assign mode_e = usr_mode_e'(mode);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VALUE;
    end else if (en) begin
      case (mode_e)
        MODE_SHR:  q <= {(rotate ? q[0] : serial_in_r), q[WIDTH-1:1]};
        MODE_SHL:  q <= {q[WIDTH-2:0], (rotate ? q[WIDTH-1] : serial_in_l)};
        MODE_LOAD: q <= parallel_in;
        default:   q <= q;
      endcase
    end
  end

  // a load restarts the word; direction changes do not
  shift_counter #(.WIDTH(WIDTH)) u_shift_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (en && (mode_e == MODE_LOAD)),
    .inc   (en && is_shift(mode)),
    .count (shift_count),
    .wrap  (word_done)
  );

  assign parallel_out = q;
  assign serial_out_r = q[0];
  assign serial_out_l = q[WIDTH-1];

endmodule
